fir_filter_top: RTL and testbench
=================================

Name: fir_filter_top

Overview:
- Top level of a 5-tap FIR benchmark block: filters a block of signed 8-bit samples held in an internal 1024x8 dual-port sample RAM and writes the results back into that RAM.
- Contains two filter engines, non-pipelined and 3-stage pipelined; `sel_pipelined` chooses one per run.
- A 32-bit cycle counter measures each run so the two engines can be compared.

Parameters:
- NUM_SAMPLES, 64, number of input samples processed per run (addresses 0..NUM_SAMPLES-1).
- OUT_BASE, 512, RAM base address of the output region; y[n] is written to OUT_BASE+n.

Ports:
- clk  input  1  system clock, all state on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  a rising edge launches a run; the level is ignored.
- sel_pipelined  input  1  0 selects the non-pipelined engine, 1 selects the pipelined engine; sampled at launch.
- done  output  1  high from run completion until the next launch.
- cycle_count  output  3  bits [2:0] of the internal 32-bit cycle counter.

Behaviour:
- Reset (asynchronous, rst=1):
  - done=0 and cycle_count=0.
  - The internal cycle_counter is cleared to 0.
  - Both engines return to IDLE.
  - RAM contents are preserved, not cleared.
- Filter definition:
  - s[n] = x[n]+x[n-1]+x[n-2]+x[n-3]+x[n-4], computed with 16-bit signed accumulation.
  - x[k] for k<0 is treated as 0.
  - y[n] = s[n] >>> 2 (arithmetic shift), saturated to the range [-128, 127].
- RAM interface:
  - Port A is read-only with a registered read: data appears 1 cycle after the address.
  - Port B is write-only.
  - Internal nets are named mem_addr_a, mem_data_out_a, mem_addr_b, mem_data_in_b and mem_we_b, and the internal counter is cycle_counter, all kept visible for hierarchical probing.
  - Port A and port B are muxed to the engine latched at launch.
  - When no run is active, mem_we_b=0.
- Launch (start rising edge while idle):
  - Latch sel_pipelined.
  - Clear done and cycle_counter.
  - Activate the selected engine.
  - A start edge while a run is active is ignored.
  - Changes to sel_pipelined during a run are ignored.
- Cycle counter: increments by 1 every clock while a run is active, then holds its final value while done=1.
- Non-pipelined engine (instance non_pipelined_filter; 4-bit state register `state`; registers current_sample and accumulator):
  - States run in the order IDLE -> for each tap k=0..4 [ADDR, ACC] -> SAT -> WRITE -> NEXT -> DONE.
  - This costs exactly 12 cycles per sample.
  - Total run length is 12*NUM_SAMPLES+2 cycles.
- Pipelined engine (instance pipelined_filter; 3-bit state register `state`; registers read_sample_idx, write_sample_idx, pipeline_active):
  - Issues one RAM read per cycle.
  - Stage 1 is a 5-entry shift window x0_s1..x4_s1, zero-filled at launch.
  - Stage 2 computes sum_s2.
  - Stage 3 computes result_s3 and output_valid_s3, then writes to RAM.
  - Sustains 1 sample per cycle.
  - Total run length is NUM_SAMPLES+6 cycles.
  - After the last read it drains with no further reads.
- Completion:
  - done rises on the cycle after the final write and stays high until the next launch or reset.
- Boundaries:
  - Writes never touch addresses 0..NUM_SAMPLES-1, so the input is unchanged.
  - Both engines produce bit-identical output.
  - Reset mid-run aborts the run with no further writes.
  - A start edge coincident with reset release is ignored.

Decomposition:
- Shared package holds:
  - DATA_W=8, ADDR_W=10, ACC_W=16, TAPS=5 and SHIFT=2.
  - The saturate function.
  - Engine state encodings.
- The one natural sub-module is the dual-port sample RAM, fir_sample_ram (1024x8, registered read port A, write port B).

Test Plan:
- Preload x[0..4]=64, x[10..14]=32, all others 0. Run non-pipelined. Expect:
  - y[0..4] = 16, 32, 48, 64, 80.
  - y[5..8] = 64, 48, 32, 16.
  - y[10..14] = 8, 16, 24, 32, 40.
  - y[15..18] = 32, 24, 16, 8.
  - done=1 and cycle_counter=770.
- Same data, pipelined run: expect identical RAM[512..575] to the non-pipelined run, and cycle_counter=70 (speedup of 11.0x).
- Hold start high for 10 cycles, then drop it: expect exactly one run, and cycle_count equals cycle_counter[2:0] throughout.
- Preload all samples = 127: expect y[n>=4] saturated to 127; all samples = -128: expect y[n>=4] = -128.
- Assert rst mid-run: expect done=0 and cycle_counter=0 immediately, no further RAM writes, and input region 0..63 unchanged. A new start then completes normally.
- Toggle sel_pipelined during a non-pipelined run: expect no effect, and the final count stays 770.

Source files
------------

// File: rtl/fir_filter_pkg.sv
// Shared widths, engine state encodings and arithmetic helpers for the
// 5-tap FIR benchmark block.
package fir_filter_pkg;

  localparam int DATA_W    = 8;
  localparam int ADDR_W    = 10;
  localparam int ACC_W     = 16;
  localparam int TAPS      = 5;
  localparam int SHIFT     = 2;
  localparam int RAM_DEPTH = 1 << ADDR_W;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [3:0] {
    NP_IDLE,
    NP_ADDR0, NP_ACC0,
    NP_ADDR1, NP_ACC1,
    NP_ADDR2, NP_ACC2,
    NP_ADDR3, NP_ACC3,
    NP_ADDR4, NP_ACC4,
    NP_SAT,
    NP_WRITE,
    NP_NEXT,
    NP_DONE
  } np_state_t;

  typedef enum logic [2:0] {
    P_IDLE,
    P_READ,
    P_DRAIN,
    P_DONE
  } p_state_t;

  function automatic logic signed [ACC_W-1:0] sext(input logic [DATA_W-1:0] v);
    return {{(ACC_W-DATA_W){v[DATA_W-1]}}, v};
  endfunction

  // Divide the tap sum by 4 (rounding toward -inf) and clamp to a signed byte.
  function automatic logic [DATA_W-1:0] saturate(input logic signed [ACC_W-1:0] sum);
    logic signed [ACC_W-1:0] shifted;
    shifted = sum >>> SHIFT;
    if (shifted > SAT_MAX) return SAT_MAX[DATA_W-1:0];
    if (shifted < SAT_MIN) return SAT_MIN[DATA_W-1:0];
    return shifted[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/fir_filter_if.sv
// Control interface of the FIR block: run launch, engine select and status.
interface fir_filter_if;

  // A rising edge on start while idle launches one run and samples
  // sel_pipelined; done stays high from completion until the next launch.
  logic       start;
  logic       sel_pipelined;
  logic       done;
  logic [2:0] cycle_count;

  modport master (output start, output sel_pipelined, input done, input cycle_count);
  modport slave  (input start, input sel_pipelined, output done, output cycle_count);

endinterface

// File: rtl/fir_filter_np.sv
// Non-pipelined FIR engine: one RAM read per tap, 12 cycles per output sample.
module fir_filter_np
  import fir_filter_pkg::*;
#(
  parameter int NUM_SAMPLES = 64,
  parameter int OUT_BASE    = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  output logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] data_out_a,
  output logic [ADDR_W-1:0] addr_b,
  output logic [DATA_W-1:0] data_in_b,
  output logic              we_b,
  output logic              finished
);

  localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_SAMPLES - 1);
  localparam logic [ADDR_W-1:0] OUT_BASE_A = ADDR_W'(OUT_BASE);

  np_state_t               state, state_next;
  logic [ADDR_W-1:0]       current_sample;
  logic signed [ACC_W-1:0] accumulator;
  logic [DATA_W-1:0]       result;
  logic [2:0]              tap_idx;
  logic                    tap_ok;

  always_comb begin
    tap_idx = 3'd0;
    case (state)
      NP_ADDR1, NP_ACC1: tap_idx = 3'd1;
      NP_ADDR2, NP_ACC2: tap_idx = 3'd2;
      NP_ADDR3, NP_ACC3: tap_idx = 3'd3;
      NP_ADDR4, NP_ACC4: tap_idx = 3'd4;
      default:           tap_idx = 3'd0;
    endcase
  end

  // Taps reaching before sample 0 contribute zero.
  assign tap_ok = (current_sample >= ADDR_W'(tap_idx));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= NP_IDLE;
      current_sample <= '0;
      accumulator    <= '0;
      result         <= '0;
    end else begin
      state <= state_next;
      case (state)
        NP_IDLE: begin
          if (go) begin
            current_sample <= '0;
            accumulator    <= '0;
          end
        end
        NP_ACC0, NP_ACC1, NP_ACC2, NP_ACC3, NP_ACC4: begin
          if (tap_ok) accumulator <= accumulator + sext(data_out_a);
        end
        NP_SAT: result <= saturate(accumulator);
        NP_NEXT: begin
          accumulator    <= '0;
          current_sample <= current_sample + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  // NEXT doubles as the tap-0 address cycle of the following sample.
  always_comb begin
    state_next = state;
    addr_a     = current_sample - ADDR_W'(tap_idx);
    addr_b     = OUT_BASE_A + current_sample;
    data_in_b  = result;
    we_b       = 1'b0;
    finished   = 1'b0;
    case (state)
      NP_IDLE:  if (go) state_next = NP_ADDR0;
      NP_ADDR0: state_next = NP_ACC0;
      NP_ACC0:  state_next = NP_ADDR1;
      NP_ADDR1: state_next = NP_ACC1;
      NP_ACC1:  state_next = NP_ADDR2;
      NP_ADDR2: state_next = NP_ACC2;
      NP_ACC2:  state_next = NP_ADDR3;
      NP_ADDR3: state_next = NP_ACC3;
      NP_ACC3:  state_next = NP_ADDR4;
      NP_ADDR4: state_next = NP_ACC4;
      NP_ACC4:  state_next = NP_SAT;
      NP_SAT:   state_next = NP_WRITE;
      NP_WRITE: begin
        we_b       = 1'b1;
        state_next = NP_NEXT;
      end
      NP_NEXT: begin
        addr_a     = current_sample + ADDR_W'(1);
        state_next = (current_sample == LAST_IDX) ? NP_DONE : NP_ACC0;
      end
      NP_DONE: begin
        finished   = 1'b1;
        state_next = NP_IDLE;
      end
      default: state_next = NP_IDLE;
    endcase
  end

endmodule

// File: rtl/fir_filter_pipe.sv
// Pipelined FIR engine: one read per cycle through a 3-stage window/sum/saturate pipe.
module fir_filter_pipe
  import fir_filter_pkg::*;
#(
  parameter int NUM_SAMPLES = 64,
  parameter int OUT_BASE    = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  output logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] data_out_a,
  output logic [ADDR_W-1:0] addr_b,
  output logic [DATA_W-1:0] data_in_b,
  output logic              we_b,
  output logic              finished
);

  localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_SAMPLES - 1);
  localparam logic [ADDR_W-1:0] NUM_A      = ADDR_W'(NUM_SAMPLES);
  localparam logic [ADDR_W-1:0] OUT_BASE_A = ADDR_W'(OUT_BASE);

  p_state_t                state, state_next;
  logic [ADDR_W-1:0]       read_sample_idx, write_sample_idx;
  logic                    pipeline_active;
  logic [DATA_W-1:0]       x0_s1, x1_s1, x2_s1, x3_s1, x4_s1;
  logic                    valid_s1, valid_s2, output_valid_s3;
  logic signed [ACC_W-1:0] sum_s2;
  logic [DATA_W-1:0]       result_s3;

  // pipeline_active marks that data_out_a carries a sample read last cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= P_IDLE;
      read_sample_idx  <= '0;
      write_sample_idx <= '0;
      pipeline_active  <= 1'b0;
      x0_s1 <= '0; x1_s1 <= '0; x2_s1 <= '0; x3_s1 <= '0; x4_s1 <= '0;
      valid_s1         <= 1'b0;
      valid_s2         <= 1'b0;
      sum_s2           <= '0;
      output_valid_s3  <= 1'b0;
      result_s3        <= '0;
    end else begin
      state <= state_next;
      if (state == P_IDLE) begin
        if (go) begin
          read_sample_idx  <= '0;
          write_sample_idx <= '0;
          pipeline_active  <= 1'b0;
          x0_s1 <= '0; x1_s1 <= '0; x2_s1 <= '0; x3_s1 <= '0; x4_s1 <= '0;
          valid_s1         <= 1'b0;
          valid_s2         <= 1'b0;
          output_valid_s3  <= 1'b0;
        end
      end else begin
        pipeline_active <= (state == P_READ);
        if (state == P_READ) read_sample_idx <= read_sample_idx + ADDR_W'(1);
        valid_s1 <= pipeline_active;
        if (pipeline_active) begin
          x0_s1 <= data_out_a;
          x1_s1 <= x0_s1;
          x2_s1 <= x1_s1;
          x3_s1 <= x2_s1;
          x4_s1 <= x3_s1;
        end
        valid_s2 <= valid_s1;
        if (valid_s1) sum_s2 <= sext(x0_s1) + sext(x1_s1) + sext(x2_s1) + sext(x3_s1) + sext(x4_s1);
        output_valid_s3 <= valid_s2;
        if (valid_s2) result_s3 <= saturate(sum_s2);
        if (output_valid_s3) write_sample_idx <= write_sample_idx + ADDR_W'(1);
      end
    end
  end

  always_comb begin
    state_next = state;
    addr_a     = read_sample_idx;
    addr_b     = OUT_BASE_A + write_sample_idx;
    data_in_b  = result_s3;
    we_b       = output_valid_s3;
    finished   = 1'b0;
    case (state)
      P_IDLE:  if (go) state_next = P_READ;
      P_READ:  if (read_sample_idx == LAST_IDX) state_next = P_DRAIN;
      P_DRAIN: if (write_sample_idx == NUM_A) state_next = P_DONE;
      P_DONE: begin
        finished   = 1'b1;
        state_next = P_IDLE;
      end
      default: state_next = P_IDLE;
    endcase
  end

endmodule

// File: rtl/fir_sample_ram.sv
// 1024x8 dual-port sample RAM: registered read on port A, write on port B.
module fir_sample_ram
  import fir_filter_pkg::*;
(
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr_a,
  output logic [DATA_W-1:0] data_out_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] data_in_b,
  input  logic              we_b
);

  logic [DATA_W-1:0] mem [RAM_DEPTH];

  // No reset: contents survive rst so a run can be repeated on the same data.
  always_ff @(posedge clk) begin
    data_out_a <= mem[addr_a];
    if (we_b) mem[addr_b] <= data_in_b;
  end

endmodule

// File: rtl/fir_filter_top.sv
// FIR benchmark top: run control, cycle counter, engine select and RAM port muxing.
module fir_filter_top
  import fir_filter_pkg::*;
#(
  parameter int NUM_SAMPLES = 64,
  parameter int OUT_BASE    = 512
) (
  input  logic         clk,
  input  logic         rst,
  fir_filter_if.slave  ctrl
);

  logic              start_q, run_active, sel_q, done_q, launch;
  logic [31:0]       cycle_counter;

  logic [ADDR_W-1:0] mem_addr_a, mem_addr_b;
  logic [DATA_W-1:0] mem_data_out_a, mem_data_in_b;
  logic              mem_we_b;

  logic [ADDR_W-1:0] np_addr_a, np_addr_b, p_addr_a, p_addr_b;
  logic [DATA_W-1:0] np_data_b, p_data_b;
  logic              np_we_b, p_we_b, np_finished, p_finished, engine_finished;

  assign launch          = ctrl.start & ~start_q & ~run_active;
  assign engine_finished = sel_q ? p_finished : np_finished;

  // start_q resets high so a start level already present at reset release is not an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q       <= 1'b1;
      run_active    <= 1'b0;
      sel_q         <= 1'b0;
      done_q        <= 1'b0;
      cycle_counter <= '0;
    end else begin
      start_q <= ctrl.start;
      if (launch) begin
        sel_q         <= ctrl.sel_pipelined;
        run_active    <= 1'b1;
        done_q        <= 1'b0;
        cycle_counter <= '0;
      end else if (run_active) begin
        cycle_counter <= cycle_counter + 32'd1;
        if (engine_finished) begin
          run_active <= 1'b0;
          done_q     <= 1'b1;
        end
      end
    end
  end

  assign ctrl.done        = done_q;
  assign ctrl.cycle_count = cycle_counter[2:0];

  assign mem_addr_a    = sel_q ? p_addr_a : np_addr_a;
  assign mem_addr_b    = sel_q ? p_addr_b : np_addr_b;
  assign mem_data_in_b = sel_q ? p_data_b : np_data_b;
  assign mem_we_b      = run_active & (sel_q ? p_we_b : np_we_b);

  fir_filter_np #(.NUM_SAMPLES(NUM_SAMPLES), .OUT_BASE(OUT_BASE)) non_pipelined_filter (
    .clk        (clk),
    .rst        (rst),
    .go         (launch & ~ctrl.sel_pipelined),
    .addr_a     (np_addr_a),
    .data_out_a (mem_data_out_a),
    .addr_b     (np_addr_b),
    .data_in_b  (np_data_b),
    .we_b       (np_we_b),
    .finished   (np_finished)
  );

  fir_filter_pipe #(.NUM_SAMPLES(NUM_SAMPLES), .OUT_BASE(OUT_BASE)) pipelined_filter (
    .clk        (clk),
    .rst        (rst),
    .go         (launch & ctrl.sel_pipelined),
    .addr_a     (p_addr_a),
    .data_out_a (mem_data_out_a),
    .addr_b     (p_addr_b),
    .data_in_b  (p_data_b),
    .we_b       (p_we_b),
    .finished   (p_finished)
  );

  fir_sample_ram u_ram (
    .clk        (clk),
    .addr_a     (mem_addr_a),
    .data_out_a (mem_data_out_a),
    .addr_b     (mem_addr_b),
    .data_in_b  (mem_data_in_b),
    .we_b       (mem_we_b)
  );

endmodule

// File: tb/tb_fir_filter_top.sv
// Self-checking bench for fir_filter_top: directed runs plus random data
// compared against an arithmetic reference of the 5-tap filter.
module tb_fir_filter_top;
  import fir_filter_pkg::*;

  localparam int N         = 64;
  localparam int OB        = 512;
  localparam int NP_CYCLES = 12 * N + 2;
  localparam int P_CYCLES  = N + 6;

  logic clk;
  logic rst;
  fir_filter_if ifc ();

  fir_filter_top #(.NUM_SAMPLES(N), .OUT_BASE(OB)) dut (
    .clk  (clk),
    .rst  (rst),
    .ctrl (ifc)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  int vectors     = 0;
  int miscompares = 0;
  int write_count = 0;
  logic [DATA_W-1:0] x_model [N];
  logic [DATA_W-1:0] exp_q [$];

  always @(posedge clk) if (dut.mem_we_b === 1'b1) write_count++;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference: sum of the last five samples (zero before the start), floor /4, clamp.
  function automatic logic [DATA_W-1:0] model_y(input int n);
    int s;
    int y;
    s = 0;
    for (int k = 0; k < 5; k++)
      if (n - k >= 0) s += int'($signed(x_model[n-k]));
    y = (s >= 0) ? s / 4 : -((-s + 3) / 4);
    if (y > 127)  y = 127;
    if (y < -128) y = -128;
    return 8'(y);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic preload();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      dut.u_ram.mem[i]      <= x_model[i];
      dut.u_ram.mem[OB + i] <= 8'($urandom);
    end
    @(posedge clk); #1;
  endtask

  task automatic launch(input logic sel);
    ifc.sel_pipelined = sel;
    @(posedge clk); #1 ifc.start = 1'b1;
    @(posedge clk); #1 ifc.start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (ifc.done !== 1'b1 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_done"}, 32'(ifc.done), 32'd1);
  endtask

  task automatic check_run(input string tag, input logic sel);
    check({tag, "_count"}, dut.cycle_counter, sel ? P_CYCLES : NP_CYCLES);
    check({tag, "_count_lsb"}, 32'(ifc.cycle_count), 32'(sel ? P_CYCLES % 8 : NP_CYCLES % 8));
    for (int i = 0; i < N; i++) exp_q.push_back(model_y(i));
    for (int i = 0; i < N; i++)
      check($sformatf("%s_y%0d", tag, i), 32'(dut.u_ram.mem[OB + i]), 32'(exp_q.pop_front()));
    for (int i = 0; i < N; i++)
      check($sformatf("%s_x%0d", tag, i), 32'(dut.u_ram.mem[i]), 32'(x_model[i]));
  endtask

  task automatic full_run(input string tag, input logic sel);
    int wc0;
    preload();
    wc0 = write_count;
    launch(sel);
    wait_done(tag, sel ? P_CYCLES + 20 : NP_CYCLES + 20);
    check_run(tag, sel);
    check({tag, "_writes"}, 32'(write_count - wc0), 32'(N));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int plan_y [19] = '{16, 32, 48, 64, 80, 64, 48, 32, 16, 0, 8, 16, 24, 32, 40, 32, 24, 16, 8};
    int wc0;
    int wc_rst;
    int n;
    logic sel;

    rst = 1'b1;
    ifc.start = 1'b0;
    ifc.sel_pipelined = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_done", 32'(ifc.done), 32'd0);
    check("reset_cycle_count", 32'(ifc.cycle_count), 32'd0);
    check("reset_counter", dut.cycle_counter, 32'd0);
    check("reset_we", 32'(dut.mem_we_b), 32'd0);

    // start already high when reset releases: no run
    ifc.start = 1'b1;
    @(negedge clk) rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("coincident_start_done", 32'(ifc.done), 32'd0);
    check("coincident_start_counter", dut.cycle_counter, 32'd0);
    check("coincident_start_writes", 32'(write_count), 32'd0);
    ifc.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // directed pulse data, non-pipelined then pipelined
    for (int i = 0; i < N; i++) x_model[i] = ((i <= 4) ? 8'd64 : ((i >= 10 && i <= 14) ? 8'd32 : 8'd0));
    full_run("plan_np", 1'b0);
    for (int i = 0; i < 19; i++) exp_q.push_back(8'(plan_y[i]));
    for (int i = 0; i < 19; i++)
      check($sformatf("plan_table_y%0d", i), 32'(dut.u_ram.mem[OB + i]), 32'(exp_q.pop_front()));
    repeat (5) @(posedge clk);
    #1;
    check("plan_np_hold", dut.cycle_counter, 32'(NP_CYCLES));
    check("plan_np_done_hold", 32'(ifc.done), 32'd1);
    full_run("plan_p", 1'b1);

    // start held high for 10 cycles: exactly one pipelined run
    preload();
    wc0 = write_count;
    ifc.sel_pipelined = 1'b1;
    ifc.start = 1'b1;
    @(posedge clk); #1;
    check("held_launch_done_low", 32'(ifc.done), 32'd0);
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      check($sformatf("held_cycle_count_%0d", k), 32'(ifc.cycle_count), 32'(k % 8));
    end
    ifc.start = 1'b0;
    wait_done("held", P_CYCLES + 20);
    repeat (100) @(posedge clk);
    #1;
    check_run("held", 1'b1);
    check("held_single_run_writes", 32'(write_count - wc0), 32'(N));

    // saturation at both rails
    for (int i = 0; i < N; i++) x_model[i] = 8'd127;
    full_run("sat_pos_np", 1'b0);
    for (int i = 0; i < N; i++) x_model[i] = 8'h80;
    full_run("sat_neg_p", 1'b1);

    // reset in the middle of a non-pipelined run
    for (int i = 0; i < N; i++) x_model[i] = 8'($urandom);
    preload();
    wc0 = write_count;
    launch(1'b0);
    repeat (300) @(posedge clk);
    #1;
    check("midrst_writes_before", 32'(write_count - wc0), 32'd25);
    #2 rst = 1'b1;
    #1;
    check("midrst_done", 32'(ifc.done), 32'd0);
    check("midrst_counter", dut.cycle_counter, 32'd0);
    check("midrst_cycle_count", 32'(ifc.cycle_count), 32'd0);
    wc_rst = write_count;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    check("midrst_no_writes", 32'(write_count - wc_rst), 32'd0);
    check("midrst_idle_counter", dut.cycle_counter, 32'd0);
    for (int i = 0; i < N; i++)
      check($sformatf("midrst_x%0d", i), 32'(dut.u_ram.mem[i]), 32'(x_model[i]));
    full_run("after_rst_p", 1'b1);

    // sel_pipelined toggled throughout a non-pipelined run
    for (int i = 0; i < N; i++) x_model[i] = 8'($urandom);
    preload();
    launch(1'b0);
    n = 0;
    while (ifc.done !== 1'b1 && n < NP_CYCLES + 20) begin
      @(posedge clk); #1;
      ifc.sel_pipelined = 1'($urandom_range(0, 1));
      n++;
    end
    check("toggle_done", 32'(ifc.done), 32'd1);
    check_run("toggle", 1'b0);

    // random data, random engine
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N; i++) x_model[i] = 8'($urandom);
      sel = 1'($urandom_range(0, 1));
      full_run($sformatf("rand%0d", r), sel);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
